// File: rtl/avalon_cpu_bridge_pkg.sv
// Shared types and constants for the CPU-to-Avalon bridge.
package avalon_bridge_pkg;

  // Bridge sequencing states; one CPU step walks IDLE..COMMIT.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECIDE,
    ST_DATA_RD,
    ST_DATA_WR,
    ST_COMMIT
  } bridge_state_t;

  // Wide all-ones constant; users slice it down to their byte-enable width.
  localparam int unsigned MAX_BE_W    = 128;
  localparam logic [MAX_BE_W-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/avalon_cpu_bridge_if.sv
// Avalon-MM master/slave signal bundle used between the bridge and the bus fabric.
interface avalon_cpu_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/avalon_wait_timer.sv
// Counts consecutive stalled cycles of one bus command and flags the cycle on
// which the stall limit is hit. TIMEOUT = 0 disables the limit entirely.
module avalon_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  output logic expired
);
  localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned LAST    = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit          ENABLED = (TIMEOUT != 0);

  logic [CNT_W-1:0] count;

  // Clear on each new command, advance on every stalled cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (busy && ENABLED) begin
      count <= count + 1'b1;
    end
  end

  // The stall that brings the count to TIMEOUT is the one that aborts.
  assign expired = ENABLED & busy & (count == LAST[CNT_W-1:0]);

endmodule

// File: rtl/avalon_cpu_bridge.sv
// Serialises the core's fetch and optional load/store onto one Avalon-MM
// master, stalling the core until the whole step has completed.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for active; launches the instruction fetch
// ST_FETCH   | fetch read on the bus, held until accepted or timed out
// ST_DECIDE  | core decodes instr_readdata; pick load, store or none
// ST_DATA_RD | load read on the bus
// ST_DATA_WR | store write on the bus
// ST_COMMIT  | cpu_enable high for this single cycle
module avalon_cpu_bridge
  import avalon_bridge_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                active,
  output logic                cpu_enable,
  input  logic [ADDR_W-1:0]   instr_address,
  output logic [DATA_W-1:0]   instr_readdata,
  input  logic [ADDR_W-1:0]   data_address,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [DATA_W/8-1:0] data_byteenable,
  input  logic [DATA_W-1:0]   data_writedata,
  output logic [DATA_W-1:0]   data_readdata,
  output logic                bus_error,
  avalon_cpu_bridge_if.master bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_ALL = BE_ALL_ONES[BE_W-1:0];

  bridge_state_t state;
  logic          cmd_start;
  logic          cmd_busy;
  logic          cmd_done;
  logic          cmd_expired;

  // A command launches out of IDLE (fetch) or DECIDE (exactly one data request).
  assign cmd_start = ((state == ST_IDLE) & active)
                   | ((state == ST_DECIDE) & (data_read ^ data_write));
  assign cmd_busy  = (bus.read | bus.write) & bus.waitrequest;
  assign cmd_done  = (bus.read | bus.write) & ~bus.waitrequest;

  avalon_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (cmd_start),
    .busy    (cmd_busy),
    .expired (cmd_expired)
  );

  // Step sequencer; every bus and core-facing output is a register here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ST_IDLE;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.address    <= '0;
      bus.byteenable <= BE_ALL;
      bus.writedata  <= '0;
      instr_readdata <= '0;
      data_readdata  <= '0;
      cpu_enable     <= 1'b0;
      bus_error      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (active) begin
            bus.address    <= instr_address;
            bus.byteenable <= BE_ALL;
            bus.read       <= 1'b1;
            state          <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (cmd_done || cmd_expired) begin
            instr_readdata <= cmd_done ? bus.readdata : '0;
            bus.read       <= 1'b0;
            if (cmd_expired) bus_error <= 1'b1;
            state          <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          case ({data_read, data_write})
            2'b10: begin
              bus.address    <= data_address;
              bus.byteenable <= data_byteenable;
              bus.read       <= 1'b1;
              state          <= ST_DATA_RD;
            end
            2'b01: begin
              bus.address    <= data_address;
              bus.byteenable <= data_byteenable;
              bus.writedata  <= data_writedata;
              bus.write      <= 1'b1;
              state          <= ST_DATA_WR;
            end
            2'b11: begin
              // Conflicting request: flag it and skip the data cycle.
              bus_error  <= 1'b1;
              cpu_enable <= 1'b1;
              state      <= ST_COMMIT;
            end
            default: begin
              cpu_enable <= 1'b1;
              state      <= ST_COMMIT;
            end
          endcase
        end
        ST_DATA_RD: begin
          if (cmd_done || cmd_expired) begin
            data_readdata <= cmd_done ? bus.readdata : '0;
            bus.read      <= 1'b0;
            if (cmd_expired) bus_error <= 1'b1;
            cpu_enable    <= 1'b1;
            state         <= ST_COMMIT;
          end
        end
        ST_DATA_WR: begin
          if (cmd_done || cmd_expired) begin
            bus.write  <= 1'b0;
            if (cmd_expired) bus_error <= 1'b1;
            cpu_enable <= 1'b1;
            state      <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          cpu_enable <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          cpu_enable <= 1'b0;
          bus.read   <= 1'b0;
          bus.write  <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_cpu_bridge.sv
// Scoreboard bench: the stimulus driver predicts bus commands and step commits
// from a step-level model; independent monitors compare what the bridge does.
module tb_avalon_cpu_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          active = 1'b0;
  logic          cpu_enable;
  logic [AW-1:0] instr_address = '0;
  logic [DW-1:0] instr_readdata;
  logic [AW-1:0] data_address = '0;
  logic          data_read = 1'b0;
  logic          data_write = 1'b0;
  logic [BW-1:0] data_byteenable = '1;
  logic [DW-1:0] data_writedata = '0;
  logic [DW-1:0] data_readdata;
  logic          bus_error;

  avalon_cpu_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  avalon_cpu_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .active          (active),
    .cpu_enable      (cpu_enable),
    .instr_address   (instr_address),
    .instr_readdata  (instr_readdata),
    .data_address    (data_address),
    .data_read       (data_read),
    .data_write      (data_write),
    .data_byteenable (data_byteenable),
    .data_writedata  (data_writedata),
    .data_readdata   (data_readdata),
    .bus_error       (bus_error),
    .bus             (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_write;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    int            hold;
  } bus_exp_t;

  typedef struct {
    logic [DW-1:0] instr;
    logic [DW-1:0] drd;
    logic          err;
    int            lat;
  } commit_exp_t;

  typedef struct {
    int            w;
    logic [DW-1:0] rdata;
  } resp_t;

  // kind: 0 none, 1 load, 2 store, 3 load+store conflict
  typedef struct {
    logic [AW-1:0] iaddr;
    logic [DW-1:0] instr;
    int            wf;
    int            kind;
    logic [AW-1:0] daddr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            wd;
  } step_t;

  bus_exp_t    bus_q[$];
  commit_exp_t commit_q[$];
  resp_t       resp_q[$];

  logic [DW-1:0] m_drd = '0;
  logic          m_err = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            commit_cnt = 0;
  int            cmd_starts = 0;
  bit            m_in_step = 1'b0;
  int            step_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=event required=none", name);
  endtask

  // Cycles a command stays on the bus for a given number of stall cycles.
  function automatic int hold_of(input int w);
    return (w >= TO) ? TO : w + 1;
  endfunction

  // Slave responder: stalls each command by its scripted count, then returns data.
  initial begin
    resp_t cur;
    int    cnt;
    bit    busy;
    busy = 1'b0;
    cnt = 0;
    cur.w = 0;
    cur.rdata = '0;
    bus_if.waitrequest = 1'b0;
    bus_if.readdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy = 1'b0;
        bus_if.waitrequest = 1'b0;
      end else if (bus_if.read || bus_if.write) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = 0;
          if (resp_q.size() > 0) cur = resp_q.pop_front();
          else begin
            cur.w = 0;
            cur.rdata = '0;
          end
        end
        bus_if.waitrequest = (cnt < cur.w);
        bus_if.readdata = bus_if.waitrequest ? $urandom : cur.rdata;
        cnt++;
      end else begin
        busy = 1'b0;
        bus_if.waitrequest = 1'($urandom_range(0, 1));
        bus_if.readdata = $urandom;
      end
    end
  end

  // Monitor: checks every bus command and every commit pulse against the queues.
  initial begin
    bus_exp_t    cur;
    commit_exp_t ce;
    logic [AW-1:0] s_addr;
    logic [BW-1:0] s_be;
    logic [DW-1:0] s_wd;
    logic [1:0]    s_rw;
    bit prev_cmd, prev_ce, have, cmd;
    int hold;
    prev_cmd = 0; prev_ce = 0; have = 0; hold = 0;
    s_addr = '0; s_be = '0; s_wd = '0; s_rw = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_cmd = 0; prev_ce = 0; have = 0; m_in_step = 0;
      end else begin
        cmd = bus_if.read | bus_if.write;
        if (m_in_step) step_cyc++;
        if (cmd && !prev_cmd) begin
          cmd_starts++;
          if (!m_in_step) begin
            m_in_step = 1;
            step_cyc = 1;
          end
          if (bus_q.size() == 0) flag("unexpected_bus_cmd");
          else begin
            cur = bus_q.pop_front();
            have = 1;
            hold = 1;
            chk("cmd_kind", {bus_if.read, bus_if.write}, cur.is_write ? 2'b01 : 2'b10);
            chk("cmd_addr", bus_if.address, cur.addr);
            chk("cmd_be", bus_if.byteenable, cur.be);
            if (cur.is_write) chk("cmd_wdata", bus_if.writedata, cur.wdata);
            s_addr = bus_if.address; s_be = bus_if.byteenable;
            s_wd = bus_if.writedata; s_rw = {bus_if.read, bus_if.write};
          end
        end else if (cmd && prev_cmd) begin
          hold++;
          if (have) begin
            chk("cmd_stable_addr", bus_if.address, s_addr);
            chk("cmd_stable_ctl", {bus_if.read, bus_if.write, bus_if.byteenable, bus_if.writedata},
                {s_rw, s_be, s_wd});
          end
        end else if (!cmd && prev_cmd && have) begin
          chk("cmd_hold_cycles", hold, cur.hold);
          have = 0;
        end
        if (cpu_enable) begin
          chk("cpu_enable_single", prev_ce, 1'b0);
          if (commit_q.size() == 0) flag("unexpected_cpu_enable");
          else begin
            ce = commit_q.pop_front();
            chk("instr_readdata", instr_readdata, ce.instr);
            chk("data_readdata", data_readdata, ce.drd);
            chk("bus_error", bus_error, ce.err);
            chk("step_latency", step_cyc, ce.lat);
          end
          commit_cnt++;
          m_in_step = 0;
        end
        prev_ce = cpu_enable;
        prev_cmd = cmd;
      end
    end
  end

  // Step-level model: predicts the bus commands and the commit outcome, then drives the core inputs.
  task automatic issue_step(input step_t s);
    bus_exp_t    b;
    commit_exp_t ce;
    resp_t       r;
    int          lat;
    b.is_write = 0; b.addr = s.iaddr; b.be = '1; b.wdata = '0; b.hold = hold_of(s.wf);
    bus_q.push_back(b);
    r.w = s.wf; r.rdata = s.instr;
    resp_q.push_back(r);
    ce.instr = (s.wf >= TO) ? '0 : s.instr;
    if (s.wf >= TO) m_err = 1'b1;
    lat = hold_of(s.wf) + 2;
    if (s.kind == 1 || s.kind == 2) begin
      b.is_write = (s.kind == 2); b.addr = s.daddr; b.be = s.be;
      b.wdata = s.wdata; b.hold = hold_of(s.wd);
      bus_q.push_back(b);
      r.w = s.wd; r.rdata = s.rdata;
      resp_q.push_back(r);
      lat += hold_of(s.wd);
      if (s.wd >= TO) m_err = 1'b1;
      if (s.kind == 1) m_drd = (s.wd >= TO) ? '0 : s.rdata;
    end else if (s.kind == 3) begin
      m_err = 1'b1;
    end
    ce.drd = m_drd; ce.err = m_err; ce.lat = lat;
    commit_q.push_back(ce);
    instr_address = s.iaddr;
    data_address = s.daddr;
    data_byteenable = s.be;
    data_writedata = s.wdata;
    data_read = (s.kind == 1 || s.kind == 3);
    data_write = (s.kind == 2 || s.kind == 3);
    active = 1'b1;
  endtask

  task automatic wait_commit(input int target);
    int i;
    i = 0;
    while (commit_cnt < target && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk("commit_reached", commit_cnt >= target, 1'b1);
  endtask

  task automatic run_step(input step_t s, input bit drop);
    int target;
    target = commit_cnt + 1;
    issue_step(s);
    if (drop) begin
      for (int i = 0; i < 20 && !m_in_step; i++) @(negedge clk);
      active = 1'b0;
    end
    wait_commit(target);
  endtask

  function automatic int pick_wait(input bit allow_err);
    if (allow_err && $urandom_range(0, 5) == 0) return $urandom_range(TO, TO + 6);
    return $urandom_range(0, TO - 1);
  endfunction

  function automatic step_t rand_step(input bit allow_err);
    step_t s;
    s.iaddr = $urandom & 32'hFFFF_FFFC;
    s.instr = $urandom;
    s.wf = pick_wait(allow_err);
    s.kind = (allow_err && $urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
    s.daddr = $urandom;
    s.be = 4'($urandom_range(1, 15));
    s.wdata = $urandom;
    s.rdata = $urandom;
    s.wd = pick_wait(allow_err);
    return s;
  endfunction

  function automatic step_t mk(input logic [AW-1:0] ia, input logic [DW-1:0] ins, input int wf,
                               input int kind, input logic [AW-1:0] da, input logic [BW-1:0] be,
                               input logic [DW-1:0] wd_data, input logic [DW-1:0] rd, input int wd);
    step_t s;
    s.iaddr = ia; s.instr = ins; s.wf = wf; s.kind = kind; s.daddr = da;
    s.be = be; s.wdata = wd_data; s.rdata = rd; s.wd = wd;
    return s;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_read"}, bus_if.read, 1'b0);
    chk({tag, "_write"}, bus_if.write, 1'b0);
    chk({tag, "_cpu_enable"}, cpu_enable, 1'b0);
    chk({tag, "_bus_error"}, bus_error, 1'b0);
    chk({tag, "_address"}, bus_if.address, '0);
    chk({tag, "_byteenable"}, bus_if.byteenable, 4'hF);
    chk({tag, "_writedata"}, bus_if.writedata, '0);
    chk({tag, "_instr_readdata"}, instr_readdata, '0);
    chk({tag, "_data_readdata"}, data_readdata, '0);
  endtask

  initial begin
    int    saved_commits;
    int    saved_starts;
    int    i;
    step_t s;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("halted_no_cmd", cmd_starts, 0);

    // lw: fetch then load, zero wait states
    run_step(mk(32'h400, 32'h8C02_0004, 0, 1, 32'h4, 4'hF, '0, 32'hDEAD_BEEF, 0), 1'b0);
    // sw with partial lanes and three stall cycles
    run_step(mk(32'h404, 32'hAC03_0008, 0, 2, 32'h8, 4'b0011, 32'h1234_5678, '0, 3), 1'b0);
    // addu: no data access
    run_step(mk(32'h408, 32'h0043_0821, 0, 0, '0, 4'hF, '0, '0, 0), 1'b0);
    for (int k = 0; k < 12; k++) run_step(rand_step(1'b0), ($urandom_range(0, 4) == 0));

    // fetch stuck in waitrequest, then a load stuck in waitrequest
    run_step(mk(32'h500, 32'h0, 50, 0, '0, 4'hF, '0, '0, 0), 1'b0);
    run_step(mk(32'h504, 32'h8C04_0010, 1, 1, 32'h10, 4'hF, '0, 32'hCAFE_F00D, 50), 1'b0);

    // reset while a store is stalled on the bus
    s = mk(32'h600, 32'hAC05_0020, 0, 2, 32'h20, 4'b1100, 32'hA5A5_5A5A, '0, 50);
    saved_commits = commit_cnt + 1;
    issue_step(s);
    i = 0;
    while (!bus_if.write && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk("store_reached_bus", bus_if.write, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    active = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    @(negedge clk);
    chk("midrst_no_commit", commit_cnt, saved_commits - 1);
    bus_q.delete();
    commit_q.delete();
    resp_q.delete();
    m_drd = '0;
    m_err = 1'b0;
    reset = 1'b1;
    saved_starts = cmd_starts;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", cmd_starts, saved_starts);

    // conflicting load+store, then halt holds the bus idle
    run_step(mk(32'h700, 32'hFFFF_FFFF, 0, 3, 32'h30, 4'hF, 32'h1, '0, 0), 1'b0);
    active = 1'b0;
    saved_commits = commit_cnt;
    saved_starts = cmd_starts;
    repeat (20) @(negedge clk);
    chk("halt_no_cmd", cmd_starts, saved_starts);
    chk("halt_no_commit", commit_cnt, saved_commits);
    chk("halt_bus_error", bus_error, 1'b1);

    for (int k = 0; k < 30; k++) run_step(rand_step(1'b1), ($urandom_range(0, 5) == 0));

    active = 1'b0;
    repeat (10) @(negedge clk);
    chk("bus_q_drained", bus_q.size(), 0);
    chk("commit_q_drained", commit_q.size(), 0);
    chk("final_bus_error", bus_error, m_err);
    chk("final_data_readdata", data_readdata, m_drd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
